// File: rtl/decode_stage.sv
// ID stage of the RV32I pipeline: instruction decode, 32x32 register file with
// write-through bypass, immediate generation and the ID/EX pipeline register.
module decode_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               instruction_decode,
   input  logic [DATA_WIDTH-1:0]     pc_decode,
   input  logic [DATA_WIDTH-1:0]     next_pc_decode,
   input  logic                      flush_execute,
   input  logic                      reg_write_writeback,
   input  logic [REG_ADDR_WIDTH-1:0] rd_writeback,
   input  logic [DATA_WIDTH-1:0]     result_writeback,
   output logic [DATA_WIDTH-1:0]     rs1_data_execute,
   output logic [DATA_WIDTH-1:0]     rs2_data_execute,
   output logic [DATA_WIDTH-1:0]     imm_execute,
   output logic [REG_ADDR_WIDTH-1:0] rs1_execute,
   output logic [REG_ADDR_WIDTH-1:0] rs2_execute,
   output logic [REG_ADDR_WIDTH-1:0] rd_execute,
   output logic [DATA_WIDTH-1:0]     pc_execute,
   output logic [DATA_WIDTH-1:0]     next_pc_execute,
   output logic [2:0]                alu_control_execute,
   output logic                      alu_src_execute,
   output logic [1:0]                result_src_execute,
   output logic                      reg_write_execute,
   output logic                      mem_write_execute,
   output logic                      branch_execute,
   output logic                      jump_execute,
   output logic [2:0]                funct3_execute,
   output logic                      illegal_execute
);

   localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   logic [6:0]                opcode;
   logic [2:0]                funct3;
   logic [REG_ADDR_WIDTH-1:0] rs1_field;
   logic [REG_ADDR_WIDTH-1:0] rs2_field;
   logic [REG_ADDR_WIDTH-1:0] rd_field;

   assign opcode    = instruction_decode[6:0];
   assign funct3    = instruction_decode[14:12];
   assign rs2_field = instruction_decode[24:20];
   assign rd_field  = instruction_decode[11:7];

   // ALU ops with no native encoding fold onto the nearest one (sltu->slt, sra->srl).
   function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3, input logic is_sub);
      case (f3)
         3'b000:  alu_from_funct3 = is_sub ? ALU_SUB : ALU_ADD;
         3'b001:  alu_from_funct3 = ALU_SLL;
         3'b010:  alu_from_funct3 = ALU_SLT;
         3'b011:  alu_from_funct3 = ALU_SLT;
         3'b100:  alu_from_funct3 = ALU_XOR;
         3'b101:  alu_from_funct3 = ALU_SRL;
         3'b110:  alu_from_funct3 = ALU_OR;
         default: alu_from_funct3 = ALU_AND;
      endcase
   endfunction

   logic [2:0] alu_control;
   logic       alu_src;
   logic [1:0] result_src;
   logic       reg_write;
   logic       mem_write;
   logic       branch;
   logic       jump;
   logic       illegal;
   logic       zero_rs1;

   always_comb begin
      alu_control = ALU_ADD;
      alu_src     = 1'b0;
      result_src  = 2'b00;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      illegal     = 1'b0;
      zero_rs1    = 1'b0;
      case (opcode)
         OP_R: begin
            reg_write   = 1'b1;
            alu_control = alu_from_funct3(funct3, instruction_decode[30]);
         end
         OP_I: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = alu_from_funct3(funct3, 1'b0);
         end
         OP_LOAD: begin
            reg_write  = 1'b1;
            alu_src    = 1'b1;
            result_src = 2'b01;
         end
         OP_STORE: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
         end
         OP_BRANCH: begin
            branch      = 1'b1;
            alu_control = ALU_SUB;
         end
         OP_JAL: begin
            jump       = 1'b1;
            reg_write  = 1'b1;
            result_src = 2'b10;
         end
         OP_LUI: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            zero_rs1  = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign rs1_field = zero_rs1 ? '0 : instruction_decode[19:15];

   logic [DATA_WIDTH-1:0] imm;

   always_comb begin
      case (opcode)
         OP_STORE:  imm = {{(DATA_WIDTH-12){instruction_decode[31]}},
                          instruction_decode[31:25], instruction_decode[11:7]};
         OP_BRANCH: imm = {{(DATA_WIDTH-12){instruction_decode[31]}}, instruction_decode[7],
                          instruction_decode[30:25], instruction_decode[11:8], 1'b0};
         OP_JAL:    imm = {{(DATA_WIDTH-20){instruction_decode[31]}}, instruction_decode[19:12],
                          instruction_decode[20], instruction_decode[30:21], 1'b0};
         OP_LUI:    imm = {{(DATA_WIDTH-32){instruction_decode[31]}},
                          instruction_decode[31:12], 12'b0};
         default:   imm = {{(DATA_WIDTH-12){instruction_decode[31]}}, instruction_decode[31:20]};
      endcase
   end

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (reg_write_writeback && rd_writeback != '0) begin
         regs[rd_writeback] <= result_writeback;
      end
   end

   // Same-cycle writeback is forwarded so the operand never sees the stale value.
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_field != '0)
         rs1_data = (reg_write_writeback && rd_writeback == rs1_field) ? result_writeback
                                                                        : regs[rs1_field];
      if (rs2_field != '0)
         rs2_data = (reg_write_writeback && rd_writeback == rs2_field) ? result_writeback
                                                                        : regs[rs2_field];
   end

   always_ff @(posedge clk) begin
      if (rst || flush_execute) begin
         rs1_data_execute    <= '0;
         rs2_data_execute    <= '0;
         imm_execute         <= '0;
         rs1_execute         <= '0;
         rs2_execute         <= '0;
         rd_execute          <= '0;
         pc_execute          <= '0;
         next_pc_execute     <= '0;
         alu_control_execute <= '0;
         alu_src_execute     <= 1'b0;
         result_src_execute  <= '0;
         reg_write_execute   <= 1'b0;
         mem_write_execute   <= 1'b0;
         branch_execute      <= 1'b0;
         jump_execute        <= 1'b0;
         funct3_execute      <= '0;
         illegal_execute     <= 1'b0;
      end else begin
         rs1_data_execute    <= rs1_data;
         rs2_data_execute    <= rs2_data;
         imm_execute         <= imm;
         rs1_execute         <= rs1_field;
         rs2_execute         <= rs2_field;
         rd_execute          <= rd_field;
         pc_execute          <= pc_decode;
         next_pc_execute     <= next_pc_decode;
         alu_control_execute <= alu_control;
         alu_src_execute     <= alu_src;
         result_src_execute  <= result_src;
         reg_write_execute   <= reg_write;
         mem_write_execute   <= mem_write;
         branch_execute      <= branch;
         jump_execute        <= jump;
         funct3_execute      <= funct3;
         illegal_execute     <= illegal;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: a behavioural decode/register-file model
// predicts the ID/EX bundle one edge after each driven instruction.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction_decode;
   logic [31:0] pc_decode;
   logic [31:0] next_pc_decode;
   logic        flush_execute;
   logic        reg_write_writeback;
   logic [4:0]  rd_writeback;
   logic [31:0] result_writeback;
   logic [31:0] rs1_data_execute, rs2_data_execute, imm_execute;
   logic [4:0]  rs1_execute, rs2_execute, rd_execute;
   logic [31:0] pc_execute, next_pc_execute;
   logic [2:0]  alu_control_execute;
   logic        alu_src_execute;
   logic [1:0]  result_src_execute;
   logic        reg_write_execute, mem_write_execute, branch_execute, jump_execute;
   logic [2:0]  funct3_execute;
   logic        illegal_execute;

   decode_stage dut (
      .clk                 (clk),
      .rst                 (rst),
      .instruction_decode  (instruction_decode),
      .pc_decode           (pc_decode),
      .next_pc_decode      (next_pc_decode),
      .flush_execute       (flush_execute),
      .reg_write_writeback (reg_write_writeback),
      .rd_writeback        (rd_writeback),
      .result_writeback    (result_writeback),
      .rs1_data_execute    (rs1_data_execute),
      .rs2_data_execute    (rs2_data_execute),
      .imm_execute         (imm_execute),
      .rs1_execute         (rs1_execute),
      .rs2_execute         (rs2_execute),
      .rd_execute          (rd_execute),
      .pc_execute          (pc_execute),
      .next_pc_execute     (next_pc_execute),
      .alu_control_execute (alu_control_execute),
      .alu_src_execute     (alu_src_execute),
      .result_src_execute  (result_src_execute),
      .reg_write_execute   (reg_write_execute),
      .mem_write_execute   (mem_write_execute),
      .branch_execute      (branch_execute),
      .jump_execute        (jump_execute),
      .funct3_execute      (funct3_execute),
      .illegal_execute     (illegal_execute)
   );

   // clock
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic        imm_valid;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] npc;
      logic [2:0]  alu;
      logic        alu_src;
      logic [1:0]  rsrc;
      logic        rw;
      logic        mw;
      logic        br;
      logic        jp;
      logic [2:0]  f3;
      logic        ill;
   } exp_t;

   localparam int EW = $bits(exp_t);
   logic [EW-1:0] exp_q[$];

   logic [31:0] model_rf [32];
   int          checks_total  = 0;
   int          checks_passed = 0;

   // ALU code for each funct3 of R/I ALU ops (sltu shares slt, sra shares srl)
   logic [2:0] alu_of_f3 [8] = '{3'd0, 3'd6, 3'd4, 3'd4, 3'd5, 3'd7, 3'd3, 3'd2};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      if (obs === exp) checks_passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] read_model(input logic [4:0] a, input logic we,
                                              input logic [4:0] rdw, input logic [31:0] wd);
      if (a == 0) return 32'd0;
      if (we && rdw == a) return wd;
      return model_rf[a];
   endfunction

   function automatic exp_t predict(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                                    input logic fl, input logic we, input logic [4:0] rdw,
                                    input logic [31:0] wd);
      exp_t e;
      logic [31:0] i_imm;
      logic [6:0]  op;
      e = '0;
      if (r || fl) return e;
      op    = inst[6:0];
      i_imm = $unsigned($signed(inst) >>> 20);
      e.imm_valid = 1'b1;
      e.rs1 = inst[19:15];
      e.rs2 = inst[24:20];
      e.rd  = inst[11:7];
      e.pc  = pc;
      e.npc = pc + 32'd4;
      e.f3  = inst[14:12];
      e.imm = i_imm;
      case (op)
         7'b0110011: begin
            e.rw = 1; e.imm_valid = 0;
            e.alu = (inst[14:12] == 3'b000 && inst[30]) ? 3'd1 : alu_of_f3[inst[14:12]];
         end
         7'b0010011: begin e.rw = 1; e.alu_src = 1; e.alu = alu_of_f3[inst[14:12]]; end
         7'b0000011: begin e.rw = 1; e.alu_src = 1; e.rsrc = 2'b01; end
         7'b0100011: begin e.mw = 1; e.alu_src = 1; e.imm = {i_imm[31:5], inst[11:7]}; end
         7'b1100011: begin
            e.br = 1; e.alu = 3'd1;
            e.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         7'b1101111: begin
            e.jp = 1; e.rw = 1; e.rsrc = 2'b10;
            e.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         7'b0110111: begin e.rw = 1; e.alu_src = 1; e.rs1 = 0; e.imm = inst & 32'hFFFF_F000; end
         default: begin e.ill = 1; e.imm_valid = 0; end
      endcase
      e.rs1_data = read_model(e.rs1, we, rdw, wd);
      e.rs2_data = read_model(e.rs2, we, rdw, wd);
      return e;
   endfunction

   task automatic compare_bundle(input exp_t e);
      check("rs1_data", rs1_data_execute, e.rs1_data);
      check("rs2_data", rs2_data_execute, e.rs2_data);
      if (e.imm_valid) check("imm", imm_execute, e.imm);
      check("rs1", 32'(rs1_execute), 32'(e.rs1));
      check("rs2", 32'(rs2_execute), 32'(e.rs2));
      check("rd", 32'(rd_execute), 32'(e.rd));
      check("pc", pc_execute, e.pc);
      check("next_pc", next_pc_execute, e.npc);
      check("alu_control", 32'(alu_control_execute), 32'(e.alu));
      check("alu_src", 32'(alu_src_execute), 32'(e.alu_src));
      check("result_src", 32'(result_src_execute), 32'(e.rsrc));
      check("reg_write", 32'(reg_write_execute), 32'(e.rw));
      check("mem_write", 32'(mem_write_execute), 32'(e.mw));
      check("branch", 32'(branch_execute), 32'(e.br));
      check("jump", 32'(jump_execute), 32'(e.jp));
      check("funct3", 32'(funct3_execute), 32'(e.f3));
      check("illegal", 32'(illegal_execute), 32'(e.ill));
   endtask

   // driver: apply one cycle of inputs, then check the bundle after the edge
   task automatic step(input logic r, input logic [31:0] inst, input logic fl,
                       input logic we, input logic [4:0] rdw, input logic [31:0] wd);
      logic [31:0] pc;
      exp_t        e;
      pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      @(negedge clk);
      rst                 = r;
      instruction_decode  = inst;
      pc_decode           = pc;
      next_pc_decode      = pc + 32'd4;
      flush_execute       = fl;
      reg_write_writeback = we;
      rd_writeback        = rdw;
      result_writeback    = wd;
      exp_q.push_back(predict(r, inst, pc, fl, we, rdw, wd));
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      end else if (we && rdw != 0) begin
         model_rf[rdw] = wd;
      end
      e = exp_q.pop_front();
      compare_bundle(e);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0]  legal [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b0110111};
      logic [31:0] inst;
      logic [6:0]  op;
      int          k;
      inst = $urandom;
      k    = $urandom_range(0, 7);
      if (k < 7) begin
         op = legal[k];
      end else begin
         op = 7'($urandom);
         while (op inside {legal}) op = 7'($urandom);
      end
      return {inst[31:7], op};
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      rst = 1'b1; instruction_decode = '0; pc_decode = '0; next_pc_decode = '0;
      flush_execute = 1'b0; reg_write_writeback = 1'b0; rd_writeback = '0;
      result_writeback = '0;

      // reset with arbitrary inputs, then read x5
      step(1, $urandom, 1'($urandom), 1, 5'd5, $urandom);
      step(1, $urandom, 1'($urandom), 1, 5'd5, $urandom);
      step(0, 32'h0002_8013, 0, 0, 0, 0);
      check("reset_x5", rs1_data_execute, 32'd0);

      // I-type after an ignored write to x0
      step(0, 32'h0000_0013, 0, 1, 5'd0, 32'd7);
      step(0, 32'h0050_0093, 0, 0, 0, 0);
      check("addi_imm", imm_execute, 32'd5);
      check("addi_rs1_data", rs1_data_execute, 32'd0);

      // R-type with bypass on rs2
      step(0, 32'h0000_0013, 0, 1, 5'd1, 32'd10);
      step(0, 32'h0000_0013, 0, 1, 5'd2, 32'd3);
      step(0, 32'h0020_81B3, 0, 1, 5'd2, 32'd9);
      check("add_rs2_bypass", rs2_data_execute, 32'd9);

      step(0, 32'h0020_A423, 0, 0, 0, 0);
      check("sw_imm", imm_execute, 32'd8);
      step(0, 32'hFE20_8EE3, 0, 0, 0, 0);
      check("beq_imm", imm_execute, 32'hFFFF_FFFC);
      step(0, 32'h1234_52B7, 0, 0, 0, 0);
      check("lui_imm", imm_execute, 32'h1234_5000);

      // flush with simultaneous writeback, then read x7
      step(0, 32'h0020_81B3, 1, 1, 5'd7, 32'h0000_DEAD);
      check("flush_reg_write", 32'(reg_write_execute), 32'd0);
      step(0, 32'h0003_8013, 0, 0, 0, 0);
      check("x7_after_flush", rs1_data_execute, 32'h0000_DEAD);

      // illegal then valid
      step(0, 32'h0000_0000, 0, 0, 0, 0);
      check("illegal_set", 32'(illegal_execute), 32'd1);
      step(0, 32'h0050_0093, 0, 0, 0, 0);
      check("illegal_clear", 32'(illegal_execute), 32'd0);

      // randomized traffic with occasional flush and mid-stream reset
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 99) < 2), rand_inst(), ($urandom_range(0, 99) < 10),
              1'($urandom), 5'($urandom), $urandom);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
